// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the UART instruction-memory loader.
//   - loader FSM state encoding and receiver state encoding
//   - byte-order constants for the length field and for instruction words
//   - default CLKS_PER_BIT / ADDR_W values
//   - join_bytes(): assembles a 16-bit value from two received bytes
package imem_loader_pkg;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_ADDR_W       = 8;

    // Both the length field and every instruction word arrive high byte first.
    localparam bit LEN_HI_FIRST  = 1'b1;
    localparam bit WORD_HI_FIRST = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_WORD_HI,
        ST_WORD_LO,
        ST_DONE,
        ST_ERR
    } ld_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    function automatic logic [15:0] join_bytes(input logic [7:0] first,
                                               input logic [7:0] second,
                                               input bit         hi_first);
        return hi_first ? {first, second} : {second, first};
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: instruction-memory write bus.
//   IMEM_WE    : one-cycle write strobe
//   IMEM_ADDR  : write address (ADDR_W bits)
//   IMEM_WDATA : write data (DATA_W bits)
// master = loader side (drives), slave = memory side (receives).
import imem_loader_pkg::*;

interface imem_loader_if #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = 16
);
    logic              IMEM_WE;
    logic [ADDR_W-1:0] IMEM_ADDR;
    logic [DATA_W-1:0] IMEM_WDATA;

    modport master (output IMEM_WE, output IMEM_ADDR, output IMEM_WDATA);
    modport slave  (input  IMEM_WE, input  IMEM_ADDR, input  IMEM_WDATA);
endinterface

// File: rtl/imem_loader_uart_rx.sv
// imem_uart_rx: 8N1 UART receiver.
//   CLK, RST   : clock, synchronous active-high reset
//   RX         : asynchronous serial input, idle high
//   rx_byte    : last received byte (valid while byte_valid is high)
//   byte_valid : one-cycle pulse, good stop bit
//   frame_err  : one-cycle pulse, stop bit sampled low (no byte)
module imem_uart_rx
    import imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    state_d = RX_START;
                    baud_d  = '0;
                end
            end
            RX_START: begin
                // Mid-start re-check: a line already back high was a glitch.
                if (baud_q == HALF_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (baud_q == FULL_LAST) begin
                    baud_d  = '0;
                    shift_d = {rx_s2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (baud_q == FULL_LAST) begin
                    baud_d  = '0;
                    valid_d = rx_s2_q;
                    ferr_d  = !rx_s2_q;
                    state_d = RX_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= RX_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_s1_q   <= RX;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign rx_byte    = shift_q;
    assign byte_valid = valid_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a program image received over UART into instruction
// memory and holds the CPU in reset until the image is complete.
// Frame: LEN_HI, LEN_LO (word count N), then N words, each HI then LO byte.
//   CLK, RST  : clock, synchronous active-high reset
//   RX        : UART serial input (8N1, idle high)
//   imem      : instruction-memory write bus (master side)
//   CPU_RST_N : low holds the CPU in reset
//   BUSY      : a frame is in progress
//   DONE      : last frame loaded successfully
//   ERR       : framing or length error, sticky until RST
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                RX,
    imem_loader_if.master       imem,
    output logic                CPU_RST_N,
    output logic                BUSY,
    output logic                DONE,
    output logic                ERR
);
    // One extra bit so N = 2^ADDR_W is representable and the index never wraps.
    localparam logic [16:0] N_MAX = 17'(1) << ADDR_W;

    logic [7:0] rx_byte;
    logic       byte_valid, frame_err;

    imem_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .CLK        (CLK),
        .RST        (RST),
        .RX         (RX),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    ld_state_e         state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d, cpu_q, cpu_d;

    logic [15:0]     len_n;
    logic [ADDR_W:0] idx_next;
    assign len_n    = join_bytes(len_hi_q, rx_byte, LEN_HI_FIRST);
    assign idx_next = idx_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        hi_d     = hi_q;
        n_d      = n_q;
        idx_d    = idx_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        cpu_d    = cpu_q;
        // Framing error has priority over everything except the sticky ERR state.
        if (frame_err && state_q != ST_ERR) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            cpu_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (byte_valid) begin
                        len_hi_d = rx_byte;
                        idx_d    = '0;
                        state_d  = ST_LEN_LO;
                        busy_d   = 1'b1;
                        done_d   = 1'b0;
                        cpu_d    = 1'b0;
                    end
                end
                ST_LEN_LO: begin
                    if (byte_valid) begin
                        if (len_n == 16'd0) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            cpu_d   = 1'b1;
                        end else if ({1'b0, len_n} > N_MAX) begin
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                            cpu_d   = 1'b0;
                        end else begin
                            n_d     = len_n[ADDR_W:0];
                            state_d = ST_WORD_HI;
                        end
                    end
                end
                ST_WORD_HI: begin
                    if (byte_valid) begin
                        hi_d    = rx_byte;
                        state_d = ST_WORD_LO;
                    end
                end
                ST_WORD_LO: begin
                    // we_q marks the write cycle; advance only after the strobe
                    // so DONE lands one cycle after the final write.
                    if (we_q) begin
                        idx_d = idx_next;
                        if (idx_next == n_q) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            cpu_d   = 1'b1;
                        end else begin
                            state_d = ST_WORD_HI;
                        end
                    end else if (byte_valid) begin
                        we_d    = 1'b1;
                        addr_d  = idx_q[ADDR_W-1:0];
                        wdata_d = DATA_W'(join_bytes(hi_q, rx_byte, WORD_HI_FIRST));
                    end
                end
                ST_ERR: begin
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            len_hi_q <= '0;
            hi_q     <= '0;
            n_q      <= '0;
            idx_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cpu_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            hi_q     <= hi_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            cpu_q    <= cpu_d;
        end
    end

    assign imem.IMEM_WE    = we_q;
    assign imem.IMEM_ADDR  = addr_q;
    assign imem.IMEM_WDATA = wdata_q;
    assign CPU_RST_N       = cpu_q;
    assign BUSY            = busy_q;
    assign DONE            = done_q;
    assign ERR             = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frame stimulus with a frame-level reference model
// feeding an expected-write queue; a monitor pops and compares each write.
module tb_imem_loader;
    localparam int CPB = 4;
    localparam int AW  = 8;
    localparam int DW  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic cpu_rst_n, busy, done, err;

    imem_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK       (clk),
        .RST       (rst),
        .RX        (rx),
        .imem      (bus),
        .CPU_RST_N (cpu_rst_n),
        .BUSY      (busy),
        .DONE      (done),
        .ERR       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        bit last;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    bit  m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0, m_cpu = 1'b0;
    bit  chk_done_next = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (chk_done_next) begin
            chk_done_next = 1'b0;
            check("done_after_last_write", {29'd0, done, cpu_rst_n, busy}, 32'b110);
        end
        if (bus.IMEM_WE === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual addr=%0h data=%0h required none",
                         bus.IMEM_ADDR, bus.IMEM_WDATA);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.IMEM_ADDR), e.addr);
                check("wr_data", 32'(bus.IMEM_WDATA), e.data);
                if (e.last) chk_done_next = 1'b1;
            end
        end
        if (dut.u_rx.byte_valid === 1'b1 && dut.u_rx.frame_err === 1'b1) begin
            failures++;
            $display("FAIL byte_valid_and_frame_err actual=both required=exclusive");
        end
    end

    // Frame-level model: bad_pos is the index of a byte sent with a low stop
    // bit (-1 for none); only bytes before it are delivered.
    task automatic model_frame(input logic [7:0] fb[$], input int bad_pos);
        int nb, n;
        wr_t w;
        if (m_err) return;
        nb = (bad_pos >= 0) ? bad_pos : fb.size();
        if (nb >= 1) begin
            m_busy = 1'b1; m_done = 1'b0; m_cpu = 1'b0;
        end
        if (nb >= 2) begin
            n = int'(fb[0]) * 256 + int'(fb[1]);
            if (n > (1 << AW)) begin
                m_err = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_cpu = 1'b0;
                return;
            end
            for (int j = 0; j < n && (3 + 2 * j) < nb; j++) begin
                w.addr = j;
                w.data = int'(fb[2 + 2 * j]) * 256 + int'(fb[3 + 2 * j]);
                w.last = (j == n - 1);
                exp_q.push_back(w);
            end
            if (bad_pos < 0 && nb >= 2 + 2 * n) begin
                m_busy = 1'b0; m_done = 1'b1; m_cpu = 1'b1;
            end
        end
        if (bad_pos >= 0) begin
            m_err = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_cpu = 1'b0;
        end
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] fb[$], input int bad_pos);
        model_frame(fb, bad_pos);
        for (int k = 0; k < fb.size(); k++) send_byte(fb[k], k != bad_pos);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'(m_busy));
        check({tag, "_done"}, 32'(done), 32'(m_done));
        check({tag, "_err"}, 32'(err), 32'(m_err));
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(m_cpu));
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        check({tag, "_pending_writes"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_cpu = 1'b0;
        exp_q.delete();
        check("rst_we", 32'(bus.IMEM_WE), 0);
        check("rst_addr", 32'(bus.IMEM_ADDR), 0);
        check("rst_wdata", 32'(bus.IMEM_WDATA), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] f[$];
        int n, bp;

        do_reset();

        // Two-word load.
        f = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        send_frame(f, -1);
        drain("two_words");
        check_status("two_words");

        // Empty frame straight from DONE.
        f = '{8'h00, 8'h00};
        send_frame(f, -1);
        drain("empty");
        check_status("empty");

        // Reload after DONE: CPU goes back into reset at the first byte.
        f = '{8'h00, 8'h01, 8'hBE, 8'hEF};
        model_frame(f, -1);
        send_byte(f[0], 1'b1);
        check("reload_cpu_rst_n", 32'(cpu_rst_n), 0);
        check("reload_busy", 32'(busy), 1);
        check("reload_done", 32'(done), 0);
        for (int k = 1; k < 4; k++) send_byte(f[k], 1'b1);
        repeat (6) @(posedge clk);
        #1;
        drain("reload");
        check_status("reload");

        // Random short frames.
        for (int r = 0; r < 4; r++) begin
            f.delete();
            n = $urandom_range(1, 5);
            f.push_back(8'h00);
            f.push_back(8'(n));
            for (int k = 0; k < 2 * n; k++) f.push_back(8'($urandom));
            send_frame(f, -1);
            drain("random");
            check_status("random");
        end

        // Largest legal frame: N = 2^ADDR_W, last address 255.
        f.delete();
        f.push_back(8'h01);
        f.push_back(8'h00);
        for (int k = 0; k < 512; k++) f.push_back(8'($urandom));
        send_frame(f, -1);
        drain("full_mem");
        check_status("full_mem");

        // N = 257 is too long; later bytes are ignored.
        f = '{8'h01, 8'h01};
        send_frame(f, -1);
        check_status("too_long");
        f = '{8'h00, 8'h01, 8'h12, 8'h34};
        send_frame(f, -1);
        drain("after_err");
        check_status("after_err");

        // One-cycle glitch in IDLE is not a byte.
        do_reset();
        rx = 1'b0;
        @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check_status("glitch");

        // Bad stop bit on the first word byte.
        f = '{8'h00, 8'h01, 8'h55};
        send_frame(f, 2);
        drain("bad_stop");
        check_status("bad_stop");

        // Reset in the middle of the third byte, then resend the whole frame.
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("mid_frame_busy", 32'(busy), 1);
        do_reset();
        f = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(f, -1);
        drain("resend");
        check_status("resend");

        // Random frame with a framing error at a random byte.
        do_reset();
        f.delete();
        f.push_back(8'h00);
        f.push_back(8'h03);
        for (int k = 0; k < 6; k++) f.push_back(8'($urandom));
        bp = $urandom_range(2, 7);
        send_frame(f, bp);
        drain("random_bad");
        check_status("random_bad");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16: CLK cycles per UART bit; legal values are 4 or more and even.
REQ-002 The block SHALL have parameter ADDR_W, default 8: instruction memory address width.
REQ-003 The block SHALL have parameter DATA_W, default 16: instruction word width; it is fixed at 2 bytes.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port RX, input, 1 bit: asynchronous UART serial line, 8N1 format, idle high.
REQ-007 The block SHALL have port IMEM_WE, output, 1 bit: one-cycle write strobe to the instruction memory.
REQ-008 The block SHALL have port IMEM_ADDR, output, ADDR_W bits: write address.
REQ-009 The block SHALL have port IMEM_WDATA, output, DATA_W bits: write data.
REQ-010 The block SHALL have port CPU_RST_N, output, 1 bit: active-low hold-in-reset for the CPU core.
REQ-011 The block SHALL have port BUSY, output, 1 bit: a frame is in progress.
REQ-012 The block SHALL have port DONE, output, 1 bit: the last frame loaded successfully.
REQ-013 The block SHALL have port ERR, output, 1 bit: framing or length error; sticky until RST.

Function
REQ-014 RX SHALL pass through a 2-flop synchronizer before any use.
REQ-015 The receiver SHALL detect a start bit on a synced-RX falling edge while the receiver is idle.
REQ-016 The receiver SHALL re-check RX low at CLKS_PER_BIT/2; if RX is high, it is a false start and the receiver returns to idle with no byte.
REQ-017 The receiver SHALL sample 8 data bits LSB-first, one every CLKS_PER_BIT cycles from the mid-start point, then sample the stop bit.
REQ-018 A stop-bit sample of 1 SHALL produce a one-cycle byte_valid pulse; a stop-bit sample of 0 SHALL produce a one-cycle frame_err pulse and no byte.
REQ-019 The frame format SHALL be: LEN_HI, LEN_LO (word count N, big-endian), then N words, each sent HI byte then LO byte.
REQ-020 The FSM SHALL have states IDLE, LEN_LO, WORD_HI, WORD_LO, DONE, ERR.
REQ-021 IDLE or DONE plus byte_valid SHALL latch LEN_HI, go to LEN_LO, set BUSY=1, DONE=0, CPU_RST_N=0, and set the word index to 0.
REQ-022 LEN_LO plus byte_valid with N=0 SHALL go to DONE.
REQ-023 LEN_LO plus byte_valid with N>2^ADDR_W SHALL go to ERR.
REQ-024 LEN_LO plus byte_valid in all other cases SHALL go to WORD_HI.
REQ-025 WORD_HI plus byte_valid SHALL latch the high byte and go to WORD_LO.
REQ-026 WORD_LO plus byte_valid SHALL, in the next cycle, assert IMEM_WE=1 with IMEM_ADDR equal to the word index and IMEM_WDATA={HI,LO}.
REQ-027 After the write in REQ-026, the word index SHALL increment; the FSM goes to DONE if index+1==N, otherwise to WORD_HI.
REQ-028 IMEM_WE SHALL assert for exactly one cycle per word; no write occurs outside WORD_LO completion.
REQ-029 Entering DONE SHALL set DONE=1, BUSY=0, CPU_RST_N=1 in the same cycle, one cycle after the final IMEM_WE.
REQ-030 A frame_err in any state other than ERR SHALL go to ERR.
REQ-031 ERR SHALL drive ERR=1, BUSY=0, DONE=0, CPU_RST_N=0, and ignore RX until RST.
REQ-032 Index arithmetic SHALL be ADDR_W+1 bits wide, so N=2^ADDR_W is legal and the last address written is 2^ADDR_W-1 with no wrap.
REQ-033 If byte_valid and frame_err coincide, frame_err SHALL win; this cannot occur by construction, and the bench asserts it never happens.

Reset
REQ-034 RST=1 at any cycle, including mid-byte or mid-frame, SHALL abort the frame, leave already-written words in memory, and not restart the load.
REQ-035 RST=1 SHALL set the FSM to IDLE and return the receiver to idle with its bit and baud counters at 0.
REQ-036 RST=1 SHALL clear IMEM_WE, IMEM_ADDR, IMEM_WDATA, BUSY, DONE, ERR and the word index to 0, and set CPU_RST_N=0.
REQ-037 The synchronizer flops SHALL reset to 1.

Structure
REQ-038 A shared package SHALL hold the FSM state encoding, the LEN and word byte-order constants, and the default CLKS_PER_BIT and ADDR_W values.
REQ-039 The design SHALL contain one sub-module, imem_uart_rx (synchronizer, baud counter, bit shifter; outputs byte, byte_valid, frame_err), instantiated once.

Verification
REQ-040 Send bytes 00 02 12 34 AB CD -> IMEM_WE pulses at addr 0 data 1234 and at addr 1 data ABCD; DONE=1 and CPU_RST_N=1 one cycle after the second pulse.
REQ-041 Send 00 00 -> no IMEM_WE, DONE=1, CPU_RST_N=1 after the second byte.
REQ-042 With ADDR_W=8, send 01 01 -> ERR=1, CPU_RST_N=0, no writes, and later bytes are ignored.
REQ-043 Send 00 01 followed by a byte with stop bit 0 -> ERR=1, no write; a 1-cycle-wide low glitch on RX in IDLE -> no byte, no state change.
REQ-044 Assert RST during the 3rd byte of 00 02 11 22 33 44 -> after RST all outputs are at reset values; resending the full frame writes 1122 and 3344 and ends with DONE=1.
REQ-045 After DONE, send 00 01 BE EF -> CPU_RST_N drops to 0 at the first byte_valid, addr 0 is written with BEEF, and DONE then reasserts.
